regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Owns both ports of the card regfile.
- Shares the write port among NUM_REQ writers (colour generator, state machine, future writers) with round-robin arbitration.
- Sequences the read port between a full-board scan for the card renderer and single-card lookups for the press checker.
- Sits between the requesters and the regfile; replaces ad-hoc write muxing with a registered req/gnt scheme.

Parameters:
- NUM_REQ, 2, number of write requesters.
- ADDR_W, 6, card address width.
- DATA_W, 8, card entry width ({colour, state}).

Ports:
- clk  in  1  pixel clock (65 MHz)
- rst  in  1  asynchronous, active-low reset
- num_of_cards  in  ADDR_W  cards on the board; scan length
- w_req  in  NUM_REQ  per-writer request; held until granted
- w_addr  in  NUM_REQ*ADDR_W  packed write addresses; writer i at [i*ADDR_W +: ADDR_W]
- w_data  in  NUM_REQ*DATA_W  packed write data
- w_gnt  out  NUM_REQ  one-hot grant; combinational, same cycle as decision
- scan_start  in  1  pulse; begin full-board read
- scan_busy  out  1  scan in progress
- scan_valid  out  1  rf_r_data holds entry scan_index
- scan_index  out  ADDR_W  address of the entry currently on rf_r_data
- scan_done  out  1  one-cycle pulse after the last entry
- rd_req  in  1  single-read request; held until rd_ack
- rd_addr  in  ADDR_W  single-read address
- rd_ack  out  1  one-cycle pulse; rf_r_data holds rd_addr entry
- rf_w_en  out  1  regfile write enable (registered)
- rf_w_addr  out  ADDR_W  regfile write address (registered)
- rf_w_data  out  DATA_W  regfile write data (registered)
- rf_r_addr  out  ADDR_W  regfile read address (registered)
- rf_r_data  in  DATA_W  regfile read data; valid 1 cycle after rf_r_addr

Behaviour:
Reset (rst low, async):
- All outputs 0; rr pointer 0; read FSM IDLE.
- Reset mid-scan or mid-read aborts the operation; no scan_done or rd_ack is issued.

Write arbitration:
- Cycle N: the first set w_req bit at or after the pointer (wrapping) is granted via w_gnt.
- Cycle N+1: rf_w_en=1 with the winner's addr/data.
- Pointer becomes (winner+1) mod NUM_REQ.
- No requests: w_gnt=0; rf_w_en=0 at N+1.
- A lone requester holding w_req gets a grant every cycle.
- One write per cycle maximum.

Read FSM: IDLE, SCAN, SINGLE.
- IDLE:
  - scan_start -> SCAN; counter=0, scan_busy=1.
  - else rd_req -> SINGLE.
  - scan_start and rd_req together: scan wins; rd_req stays pending.
- SCAN:
  - Issue rf_r_addr=counter each cycle, counter 0..num_of_cards-1.
  - scan_valid and scan_index follow one cycle later.
  - After the last issue, return to IDLE.
  - scan_done pulses in the cycle the last scan_valid is high.
  - scan_busy drops the cycle after scan_done.
  - scan_start while busy is ignored.
  - num_of_cards=0: no reads; scan_done pulses the cycle after scan_start.
- SINGLE:
  - Issue rf_r_addr=rd_addr; rd_ack pulses one cycle later; return to IDLE.
  - Read-after-write hazard: if the address being issued equals rf_w_addr of a write in the same output cycle, defer the issue one cycle so the new data is returned.
  - A scan_start arriving in SINGLE is latched and begins immediately after rd_ack.
- Read latency: single read 2 cycles from rd_req (IDLE, no hazard) to rd_ack; scan entry k valid at cycle k+2 after scan_start.
- Counter wraps never; it is compared against num_of_cards-1 at full ADDR_W width.

Decomposition:
- Shared package (extends the card macros header): ADDR_W/DATA_W defaults tied to the card address/data size macros, read FSM state encodings, writer index constants (WR_COLORS=0, WR_STATE=1).
- One sub-module: rr_arbiter (NUM_REQ req vector + pointer -> one-hot grant + next pointer); the rest stays in regfile_arbiter.

Test Plan:
- Reset held low, then released, all inputs 0 -> all outputs 0; first w_req[0] grants at pointer 0.
- w_req=2'b11 held for 4 cycles -> w_gnt sequence 01,10,01,10; rf_w_addr follows the winners one cycle later.
- num_of_cards=12, scan_start pulse -> rf_r_addr 0..11 on consecutive cycles, scan_valid 12 cycles with scan_index 0..11, scan_done on index 11; num_of_cards=0 -> scan_done only, no scan_valid.
- rd_req addr 5 together with scan_start -> 12 scan reads first, then rd_ack 2 cycles after scan_busy falls with the regfile[5] value.
- Writer 1 writes 0x3A to addr 7 while rd_req addr 7 is issued in the same cycle -> read deferred one cycle; rd_ack returns 0x3A.
- Assert rst low during scan index 6 -> scan_busy=0 immediately, no scan_done; a new scan after release starts at 0.

Source files
------------

// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the card regfile arbiter: card entry geometry,
// read-sequencer state encodings and fixed writer slot assignments.
package regfile_arbiter_pkg;

    localparam int unsigned CARD_ADDR_W = 6;
    localparam int unsigned CARD_DATA_W = 8;

    localparam logic [1:0] RD_IDLE   = 2'd0;
    localparam logic [1:0] RD_SCAN   = 2'd1;
    localparam logic [1:0] RD_SINGLE = 2'd2;

    localparam int unsigned WR_COLORS = 0;
    localparam int unsigned WR_STATE  = 1;

endpackage

// File: rtl/regfile_arbiter_rr.sv
// Round-robin grant: picks the first request at or after the pointer
// (wrapping) and reports where the pointer moves to.
module rr_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   next_ptr
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                next_ptr = PTR_W'((idx + 1) % NUM_REQ);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Owns both regfile ports: round-robin write sharing plus a read sequencer
// for full-board scans and single-card lookups.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = CARD_ADDR_W,
    parameter int unsigned DATA_W  = CARD_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         num_of_cards,
    input  logic [NUM_REQ-1:0]        w_req,
    input  logic [NUM_REQ*ADDR_W-1:0] w_addr,
    input  logic [NUM_REQ*DATA_W-1:0] w_data,
    output logic [NUM_REQ-1:0]        w_gnt,
    input  logic                      scan_start,
    output logic                      scan_busy,
    output logic                      scan_valid,
    output logic [ADDR_W-1:0]         scan_index,
    output logic                      scan_done,
    input  logic                      rd_req,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_ack,
    output logic                      rf_w_en,
    output logic [ADDR_W-1:0]         rf_w_addr,
    output logic [DATA_W-1:0]         rf_w_data,
    output logic [ADDR_W-1:0]         rf_r_addr,
    input  logic [DATA_W-1:0]         rf_r_data
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] gnt_raw;
    logic               win_any;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req      (w_req),
        .ptr      (rr_ptr),
        .gnt      (gnt_raw),
        .next_ptr (rr_next)
    );

    assign w_gnt   = rst ? gnt_raw : '0;
    assign win_any = |w_gnt;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                win_addr = win_addr | w_addr[i*ADDR_W +: ADDR_W];
                win_data = win_data | w_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            rf_w_en   <= 1'b0;
            rf_w_addr <= '0;
            rf_w_data <= '0;
        end else begin
            rf_w_en <= win_any;
            rr_ptr  <= rr_next;
            if (win_any) begin
                rf_w_addr <= win_addr;
                rf_w_data <= win_data;
            end
        end
    end

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] last_idx;
    logic              iss_scan;
    logic              iss_last;
    logic              iss_single;
    logic              defer;
    logic              scan_pend;
    logic              scan_req;
    logic              start_scan;
    logic              start_rd;
    logic              rd_hazard;

    // A scan may also launch straight out of SINGLE on the rd_ack cycle.
    assign last_idx   = num_of_cards - ADDR_W'(1);
    assign scan_req   = scan_start | scan_pend;
    assign start_scan = scan_req && ((state == RD_IDLE && !scan_busy) ||
                                     (state == RD_SINGLE && rd_ack));
    assign start_rd   = (state == RD_IDLE) && !scan_busy && !scan_req && rd_req;
    assign rd_hazard  = win_any && (win_addr == rd_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RD_IDLE;
            cnt        <= '0;
            iss_scan   <= 1'b0;
            iss_last   <= 1'b0;
            iss_single <= 1'b0;
            defer      <= 1'b0;
            scan_pend  <= 1'b0;
            scan_busy  <= 1'b0;
            scan_valid <= 1'b0;
            scan_index <= '0;
            scan_done  <= 1'b0;
            rd_ack     <= 1'b0;
            rf_r_addr  <= '0;
        end else begin
            iss_scan   <= 1'b0;
            iss_last   <= 1'b0;
            iss_single <= 1'b0;
            scan_valid <= iss_scan;
            scan_done  <= iss_last;
            rd_ack     <= iss_single;
            if (iss_scan)
                scan_index <= rf_r_addr;
            if (scan_done)
                scan_busy <= 1'b0;
            if (state == RD_SINGLE && scan_start)
                scan_pend <= 1'b1;

            if (start_scan) begin
                scan_pend <= 1'b0;
                scan_busy <= 1'b1;
                if (num_of_cards == '0) begin
                    scan_done <= 1'b1;
                    state     <= RD_IDLE;
                end else begin
                    rf_r_addr <= '0;
                    iss_scan  <= 1'b1;
                    cnt       <= ADDR_W'(1);
                    if (last_idx == '0) begin
                        iss_last <= 1'b1;
                        state    <= RD_IDLE;
                    end else begin
                        state <= RD_SCAN;
                    end
                end
            end else if (start_rd) begin
                state <= RD_SINGLE;
                // Same-cycle write to this address: read one cycle later.
                if (rd_hazard) begin
                    defer <= 1'b1;
                end else begin
                    rf_r_addr  <= rd_addr;
                    iss_single <= 1'b1;
                end
            end else begin
                case (state)
                    RD_SCAN: begin
                        rf_r_addr <= cnt;
                        iss_scan  <= 1'b1;
                        cnt       <= cnt + ADDR_W'(1);
                        if (cnt == last_idx) begin
                            iss_last <= 1'b1;
                            state    <= RD_IDLE;
                        end
                    end
                    RD_SINGLE: begin
                        if (defer) begin
                            rf_r_addr  <= rd_addr;
                            iss_single <= 1'b1;
                            defer      <= 1'b0;
                        end else if (rd_ack) begin
                            state <= RD_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural synchronous-read
// regfile attached to the rf_* port.
module tb_regfile_arbiter;

    logic        clk;
    logic        rst;
    logic [5:0]  num_of_cards;
    logic [1:0]  w_req;
    logic [11:0] w_addr;
    logic [15:0] w_data;
    logic [1:0]  w_gnt;
    logic        scan_start;
    logic        scan_busy;
    logic        scan_valid;
    logic [5:0]  scan_index;
    logic        scan_done;
    logic        rd_req;
    logic [5:0]  rd_addr;
    logic        rd_ack;
    logic        rf_w_en;
    logic [5:0]  rf_w_addr;
    logic [7:0]  rf_w_data;
    logic [5:0]  rf_r_addr;
    logic [7:0]  rf_r_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [64];

    regfile_arbiter #(.NUM_REQ(2), .ADDR_W(6), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .num_of_cards (num_of_cards),
        .w_req        (w_req),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .w_gnt        (w_gnt),
        .scan_start   (scan_start),
        .scan_busy    (scan_busy),
        .scan_valid   (scan_valid),
        .scan_index   (scan_index),
        .scan_done    (scan_done),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ack       (rd_ack),
        .rf_w_en      (rf_w_en),
        .rf_w_addr    (rf_w_addr),
        .rf_w_data    (rf_w_data),
        .rf_r_addr    (rf_r_addr),
        .rf_r_data    (rf_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 7 + 17) & 255);
    endfunction

    // Regfile: write and registered read on the same edge return old data.
    always @(posedge clk) begin
        if (rf_w_en) mem[rf_w_addr] <= rf_w_data;
        rf_r_data <= mem[rf_r_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; num_of_cards = '0; w_req = '0; w_addr = '0; w_data = '0;
        scan_start = 1'b0; rd_req = 1'b0; rd_addr = '0;
        repeat (3) next_cycle();
        #1;
        checks++;
        if ({w_gnt, scan_busy, scan_valid, scan_index, scan_done, rd_ack, rf_w_en, rf_w_addr, rf_w_data, rf_r_addr} !== '0) begin
            errors++; $display("FAIL reset_held: outputs not all zero (gnt=%b busy=%b wen=%b)", w_gnt, scan_busy, rf_w_en);
        end
        next_cycle(); rst = 1'b1;
        next_cycle(); #1;
        checks++;
        if ({w_gnt, scan_busy, scan_valid, scan_index, scan_done, rd_ack, rf_w_en, rf_w_addr, rf_w_data, rf_r_addr} !== '0) begin
            errors++; $display("FAIL reset_released: outputs not all zero (gnt=%b busy=%b wen=%b)", w_gnt, scan_busy, rf_w_en);
        end
        next_cycle(); w_req = 2'b01; w_addr[5:0] = 6'd40; w_data[7:0] = 8'h11; #1;
        checks++;
        if (w_gnt !== 2'b01) begin errors++; $display("FAIL first_grant: got %b expected 01", w_gnt); end
        next_cycle(); w_req = 2'b10; w_addr[11:6] = 6'd41; w_data[15:8] = 8'h22; #1;
        checks++;
        if ({rf_w_en, rf_w_addr, rf_w_data} !== {1'b1, 6'd40, 8'h11}) begin
            errors++; $display("FAIL first_write: got en=%b a=%0d d=%h expected 1/40/11", rf_w_en, rf_w_addr, rf_w_data);
        end
        checks++;
        if (w_gnt !== 2'b10) begin errors++; $display("FAIL lone_w1_grant: got %b expected 10", w_gnt); end
        next_cycle(); w_req = 2'b00; #1;
        checks++;
        if ({rf_w_en, rf_w_addr, rf_w_data} !== {1'b1, 6'd41, 8'h22}) begin
            errors++; $display("FAIL second_write: got en=%b a=%0d d=%h expected 1/41/22", rf_w_en, rf_w_addr, rf_w_data);
        end
        checks++;
        if (w_gnt !== 2'b00) begin errors++; $display("FAIL idle_grant: got %b expected 00", w_gnt); end
        next_cycle(); #1;
        checks++;
        if (rf_w_en !== 1'b0) begin errors++; $display("FAIL idle_wen: got %b expected 0", rf_w_en); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        logic [5:0] prev_a;
        w_addr = {6'd43, 6'd42}; w_data = {8'hB1, 8'hA0};
        prev_a = '0;
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            w_req = (k < 4) ? 2'b11 : 2'b10;
            #1;
            exp_g = (k < 4) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b10;
            checks++;
            if (w_gnt !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, w_gnt, exp_g); end
            if (k > 0) begin
                checks++;
                if ({rf_w_en, rf_w_addr} !== {1'b1, prev_a}) begin
                    errors++; $display("FAIL rr_waddr[%0d]: got en=%b a=%0d expected 1/%0d", k, rf_w_en, rf_w_addr, prev_a);
                end
            end
            prev_a = exp_g[0] ? 6'd42 : 6'd43;
        end
        next_cycle(); w_req = 2'b00; #1;
        checks++;
        if ({rf_w_en, rf_w_addr} !== {1'b1, prev_a}) begin
            errors++; $display("FAIL rr_waddr_last: got en=%b a=%0d expected 1/%0d", rf_w_en, rf_w_addr, prev_a);
        end
        next_cycle(); #1;
    endtask

    task automatic test_scan();
        next_cycle(); num_of_cards = 6'd12; scan_start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            next_cycle(); scan_start = 1'b0; #1;
            checks++;
            if (scan_busy !== (k <= 13)) begin errors++; $display("FAIL scan_busy[%0d]: got %b expected %b", k, scan_busy, (k <= 13)); end
            if (k <= 12) begin
                checks++;
                if (rf_r_addr !== 6'(k - 1)) begin errors++; $display("FAIL scan_raddr[%0d]: got %0d expected %0d", k, rf_r_addr, k - 1); end
            end
            checks++;
            if (scan_valid !== (k >= 2 && k <= 13)) begin errors++; $display("FAIL scan_valid[%0d]: got %b", k, scan_valid); end
            if (k >= 2 && k <= 13) begin
                checks++;
                if ({scan_index, rf_r_data} !== {6'(k - 2), init_val(k - 2)}) begin
                    errors++; $display("FAIL scan_entry[%0d]: got idx=%0d d=%h expected %0d/%h", k, scan_index, rf_r_data, k - 2, init_val(k - 2));
                end
            end
            checks++;
            if (scan_done !== (k == 13)) begin errors++; $display("FAIL scan_done[%0d]: got %b expected %b", k, scan_done, (k == 13)); end
        end
    endtask

    task automatic test_scan_zero();
        next_cycle(); num_of_cards = 6'd0; scan_start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            next_cycle(); scan_start = 1'b0; #1;
            checks++;
            if ({scan_done, scan_busy, scan_valid} !== {(k == 1), (k == 1), 1'b0}) begin
                errors++; $display("FAIL scan_zero[%0d]: got done=%b busy=%b valid=%b", k, scan_done, scan_busy, scan_valid);
            end
        end
    endtask

    task automatic test_scan_vs_read();
        int fall_cycle, ack_cycle, nvalid;
        logic [7:0] ack_data;
        fall_cycle = -1; ack_cycle = -1; nvalid = 0; ack_data = '0;
        next_cycle(); num_of_cards = 6'd12; scan_start = 1'b1; rd_req = 1'b1; rd_addr = 6'd5;
        for (int k = 1; k <= 24; k++) begin
            next_cycle(); scan_start = 1'b0; #1;
            if (scan_valid) nvalid++;
            if (!scan_busy && fall_cycle < 0) fall_cycle = k;
            if (rd_ack && ack_cycle < 0) begin ack_cycle = k; ack_data = rf_r_data; rd_req = 1'b0; end
        end
        checks++;
        if (nvalid !== 12) begin errors++; $display("FAIL svr_nvalid: got %0d expected 12", nvalid); end
        checks++;
        if (fall_cycle !== 14) begin errors++; $display("FAIL svr_busy_fall: got %0d expected 14", fall_cycle); end
        checks++;
        if (ack_cycle !== 16) begin errors++; $display("FAIL svr_ack_cycle: got %0d expected 16", ack_cycle); end
        checks++;
        if (ack_data !== init_val(5)) begin errors++; $display("FAIL svr_ack_data: got %h expected %h", ack_data, init_val(5)); end
        rd_req = 1'b0;
    endtask

    task automatic test_single_then_scan();
        next_cycle(); num_of_cards = 6'd3; rd_req = 1'b1; rd_addr = 6'd9; #1;
        checks++;
        if (rd_ack !== 1'b0) begin errors++; $display("FAIL single_c0_ack: got %b expected 0", rd_ack); end
        next_cycle(); scan_start = 1'b1; #1;
        checks++;
        if ({rd_ack, rf_r_addr} !== {1'b0, 6'd9}) begin errors++; $display("FAIL single_c1: got ack=%b ra=%0d expected 0/9", rd_ack, rf_r_addr); end
        next_cycle(); scan_start = 1'b0; #1;
        checks++;
        if ({rd_ack, rf_r_data, scan_busy} !== {1'b1, init_val(9), 1'b0}) begin
            errors++; $display("FAIL single_ack: got ack=%b d=%h busy=%b expected 1/%h/0", rd_ack, rf_r_data, scan_busy, init_val(9));
        end
        rd_req = 1'b0;
        next_cycle(); #1;
        checks++;
        if ({rd_ack, scan_busy, rf_r_addr} !== {1'b0, 1'b1, 6'd0}) begin
            errors++; $display("FAIL latched_scan_start: got ack=%b busy=%b ra=%0d expected 0/1/0", rd_ack, scan_busy, rf_r_addr);
        end
        for (int k = 4; k <= 7; k++) begin
            next_cycle(); #1;
            checks++;
            if ({scan_valid, scan_done, scan_busy} !== {(k <= 6), (k == 6), (k <= 6)}) begin
                errors++; $display("FAIL latched_scan[%0d]: got v=%b d=%b b=%b", k, scan_valid, scan_done, scan_busy);
            end
            if (k <= 6) begin
                checks++;
                if (scan_index !== 6'(k - 4)) begin errors++; $display("FAIL latched_idx[%0d]: got %0d expected %0d", k, scan_index, k - 4); end
            end
        end
    endtask

    task automatic test_raw_hazard();
        next_cycle(); next_cycle();
        w_req = 2'b10; w_addr[11:6] = 6'd7; w_data[15:8] = 8'h3A; rd_req = 1'b1; rd_addr = 6'd7; #1;
        checks++;
        if (w_gnt !== 2'b10) begin errors++; $display("FAIL raw_gnt: got %b expected 10", w_gnt); end
        next_cycle(); w_req = 2'b00; #1;
        checks++;
        if ({rf_w_en, rf_w_addr, rd_ack} !== {1'b1, 6'd7, 1'b0}) begin
            errors++; $display("FAIL raw_c1: got en=%b wa=%0d ack=%b expected 1/7/0", rf_w_en, rf_w_addr, rd_ack);
        end
        next_cycle(); #1;
        checks++;
        if ({rd_ack, rf_r_addr} !== {1'b0, 6'd7}) begin errors++; $display("FAIL raw_defer: got ack=%b ra=%0d expected 0/7", rd_ack, rf_r_addr); end
        next_cycle(); #1;
        checks++;
        if ({rd_ack, rf_r_data} !== {1'b1, 8'h3A}) begin errors++; $display("FAIL raw_ack: got ack=%b d=%h expected 1/3a", rd_ack, rf_r_data); end
        rd_req = 1'b0;
        next_cycle(); #1;
        checks++;
        if (rd_ack !== 1'b0) begin errors++; $display("FAIL raw_ack_pulse: got %b expected 0", rd_ack); end
    endtask

    task automatic test_reset_mid_scan();
        logic saw;
        next_cycle(); next_cycle(); num_of_cards = 6'd12; scan_start = 1'b1;
        for (int k = 1; k <= 8; k++) begin next_cycle(); scan_start = 1'b0; end
        #1;
        checks++;
        if ({scan_valid, scan_index} !== {1'b1, 6'd6}) begin errors++; $display("FAIL mid_scan_idx6: got v=%b idx=%0d expected 1/6", scan_valid, scan_index); end
        rst = 1'b0; #1;
        checks++;
        if ({scan_busy, scan_valid, scan_done, rf_r_addr} !== '0) begin
            errors++; $display("FAIL mid_scan_reset: got busy=%b v=%b d=%b ra=%0d expected all 0", scan_busy, scan_valid, scan_done, rf_r_addr);
        end
        next_cycle(); next_cycle(); rst = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 15; k++) begin next_cycle(); if (scan_done || scan_busy) saw = 1'b1; end
        checks++;
        if (saw !== 1'b0) begin errors++; $display("FAIL mid_scan_no_done: got activity=%b expected 0", saw); end
        num_of_cards = 6'd3; scan_start = 1'b1;
        next_cycle(); scan_start = 1'b0; #1;
        checks++;
        if ({scan_busy, rf_r_addr} !== {1'b1, 6'd0}) begin errors++; $display("FAIL rescan_start: got busy=%b ra=%0d expected 1/0", scan_busy, rf_r_addr); end
        next_cycle(); #1;
        checks++;
        if ({scan_valid, scan_index} !== {1'b1, 6'd0}) begin errors++; $display("FAIL rescan_idx0: got v=%b idx=%0d expected 1/0", scan_valid, scan_index); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = init_val(i);
        test_reset();
        test_round_robin();
        test_scan();
        test_scan_zero();
        test_scan_vs_read();
        test_single_then_scan();
        test_raw_hazard();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
